// File: rtl/bit_place_lane_arbiter.sv
// -----------------------------------------------------------------------------
// bit_place_lane_arbiter
//
// Round-robin scheduler that shares one downstream bit-serial shift-add unit
// among NUM_LANES BitConverterFIFO lanes. Each grant pops 3-bit bit places from
// one lane's FIFO (registered read: rd_en in cycle t, data valid in t+1) and
// presents them, tagged with the lane index, on a valid/ready output. A lane
// keeps the unit for at most MAX_BURST consecutive places, then the search
// pointer moves past it.
//
// Ports
//   CLK             clock, all logic on posedge
//   RSTN            synchronous reset, active-high
//   Enable          1 = new grants / burst continuation allowed
//   LaneReadReady   per-lane FIFO non-empty
//   LaneReadData    per-lane FIFO read data, lane i at [3*i+2:3*i]
//   LaneReadEnable  per-lane FIFO pop, one-hot or zero, single-cycle pulse
//   OutValid        OutPlace/OutLane valid
//   OutReady        downstream accepts when OutValid & OutReady
//   OutPlace        bit place 0..7
//   OutLane         source lane of OutPlace
//   Busy            high whenever the FSM is not idle
//   IssueCount      accepted handshakes, wraps mod 2^CNT_W
// -----------------------------------------------------------------------------
module bit_place_lane_arbiter #(
   parameter int NUM_LANES = 4,
   parameter int LANE_W    = $clog2(NUM_LANES),
   parameter int MAX_BURST = 8,
   parameter int CNT_W     = 16
) (
   input  logic                   CLK,
   input  logic                   RSTN,
   input  logic                   Enable,
   input  logic [NUM_LANES-1:0]   LaneReadReady,
   input  logic [NUM_LANES*3-1:0] LaneReadData,
   output logic [NUM_LANES-1:0]   LaneReadEnable,
   output logic                   OutValid,
   input  logic                   OutReady,
   output logic [2:0]             OutPlace,
   output logic [LANE_W-1:0]      OutLane,
   output logic                   Busy,
   output logic [CNT_W-1:0]       IssueCount
);

   // Burst counter holds 0..MAX_BURST-1 (index of the place being issued).
   localparam int BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [BC_W-1:0]   BURST_LAST = BC_W'(MAX_BURST - 1);
   localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(NUM_LANES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t              state;
   state_t              nextState;
   logic [LANE_W-1:0]   grant;
   logic [LANE_W-1:0]   rrPtr;
   logic [BC_W-1:0]     burstCnt;

   logic [LANE_W-1:0]   probe;
   logic [LANE_W-1:0]   searchLane;
   logic                searchHit;
   logic [LANE_W-1:0]   nextPtr;
   logic                handshake;
   logic                burstGo;
   logic                newGrant;

   // Round-robin search: first ready lane starting at rrPtr, wrapping at
   // NUM_LANES (explicit wrap keeps non-power-of-two lane counts in range).
   always_comb begin
      searchHit  = 1'b0;
      searchLane = rrPtr;
      probe      = rrPtr;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (!searchHit && LaneReadReady[probe]) begin
            searchHit  = 1'b1;
            searchLane = probe;
         end
         probe = (probe == LAST_LANE) ? '0 : probe + 1'b1;
      end
   end

   assign nextPtr   = (grant == LAST_LANE) ? '0 : grant + 1'b1;
   assign handshake = (state == S_OUT) && OutValid && OutReady;
   // Continue the burst only while enabled, the lane still has data and the
   // quota is not yet used up; otherwise hand the unit to the next lane.
   assign burstGo   = handshake && Enable && LaneReadReady[grant] &&
                      (burstCnt < BURST_LAST);
   assign newGrant  = (state == S_IDLE) && Enable && searchHit;
   assign Busy      = (state != S_IDLE);

   // Next-state and FIFO pop decode
   always_comb begin
      nextState      = state;
      LaneReadEnable = '0;
      case (state)
         S_IDLE: begin
            if (newGrant) begin
               LaneReadEnable[searchLane] = 1'b1;
               nextState                  = S_READ;
            end
         end
         S_READ: begin
            nextState = S_OUT;
         end
         S_OUT: begin
            if (handshake) begin
               if (burstGo) begin
                  LaneReadEnable[grant] = 1'b1;
                  nextState             = S_READ;
               end else begin
                  nextState = S_IDLE;
               end
            end
         end
         default: begin
            nextState = S_IDLE;
         end
      endcase
      // No FIFO pop may leak out while reset is being applied.
      if (RSTN) begin
         LaneReadEnable = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RSTN) begin
         state <= S_IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Grant, pointer, burst and output registers
   always_ff @(posedge CLK) begin
      if (RSTN) begin
         grant      <= '0;
         rrPtr      <= '0;
         burstCnt   <= '0;
         OutValid   <= 1'b0;
         OutPlace   <= '0;
         OutLane    <= '0;
         IssueCount <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (newGrant) begin
                  grant    <= searchLane;
                  burstCnt <= '0;
               end
            end
            S_READ: begin
               // FIFO data for the pop issued last cycle is valid now.
               OutPlace <= LaneReadData[int'(grant)*3 +: 3];
               OutLane  <= grant;
               OutValid <= 1'b1;
            end
            S_OUT: begin
               if (handshake) begin
                  IssueCount <= IssueCount + 1'b1;
                  OutValid   <= 1'b0;
                  if (burstGo) begin
                     burstCnt <= burstCnt + 1'b1;
                  end else begin
                     rrPtr <= nextPtr;
                  end
               end
            end
            default: begin
               OutValid <= 1'b0;
            end
         endcase
      end
   end

endmodule
